// File: rtl/frame_streamer_if.sv
// Output sample stream: valid/ready handshake carrying a sample and its frame markers.
interface frame_streamer_if #(
  parameter int DATA_W = 32
) ();
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;
  logic              first;
  logic              last;

  modport master (output data, output valid, output first, output last, input ready);
  modport slave  (input data, input valid, input first, input last, output ready);
endinterface

// File: rtl/frame_streamer.sv
// Frame sequencer: reads overlapping N-sample frames (stride HOP, wrap at L) from a
// fixed-latency circular source and streams them out through a credit-controlled skid FIFO.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing source reads while FIFO credit allows
// DRAIN | all reads issued, waiting for returns and FIFO to empty
// DONE  | one-cycle completion pulse
// FLUSH | aborted, waiting for any in-flight returns to be discarded
module frame_streamer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int L      = 1000,
  parameter int N      = 256,
  parameter int HOP    = 64,
  parameter int RD_LAT = 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [15:0]         i_num_frames,
  input  logic                i_abort,
  output logic                o_src_en,
  output logic [ADDR_W-1:0]   o_src_addr,
  input  logic [DATA_W-1:0]   i_src_data,
  frame_streamer_if.master    m_if,
  output logic [15:0]         o_frame_idx,
  output logic                o_busy,
  output logic                o_done
);
  localparam int DEPTH  = RD_LAT + 2;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int SAMP_W = $clog2(N + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_addr;
  logic [SAMP_W-1:0] r_samp_left;
  logic [15:0]       r_frame_cnt;
  logic [15:0]       r_num_frames;
  logic [15:0]       r_frame_idx;

  logic [RD_LAT-1:0] r_pipe_vld;
  logic [RD_LAT-1:0] r_pipe_first;
  logic [RD_LAT-1:0] r_pipe_last;

  // FIFO entry layout: {last, first, data}
  logic [DATA_W+1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic [CNT_W-1:0]  w_inflight;
  logic [CNT_W:0]    w_occupancy;
  logic              w_start_act;
  logic              w_abort_act;
  logic              w_issue;
  logic              w_last_samp;
  logic              w_last_frame;
  logic              w_wr;
  logic              w_pop;
  logic              w_drained;
  logic [DATA_W+1:0] w_head;
  logic [ADDR_W:0]   w_base_sum;
  logic [ADDR_W:0]   w_addr_sum;
  logic [ADDR_W-1:0] w_base_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;

  // Reads in flight = tags still travelling down the latency line.
  always_comb begin
    w_inflight = '0;
    for (int k = 0; k < RD_LAT; k++) begin
      w_inflight = w_inflight + CNT_W'(r_pipe_vld[k]);
    end
  end

  assign w_occupancy  = {1'b0, r_count} + {1'b0, w_inflight};
  assign w_start_act  = i_start && !i_abort && (r_state == S_IDLE);
  assign w_abort_act  = i_abort && ((r_state == S_RUN) || (r_state == S_DRAIN));
  assign w_issue      = (r_state == S_RUN) && (w_occupancy < (CNT_W+1)'(DEPTH));
  assign w_last_samp  = (r_samp_left == '0);
  assign w_last_frame = (r_num_frames != 16'd0) && (r_frame_cnt == r_num_frames - 16'd1);
  assign w_wr         = r_pipe_vld[RD_LAT-1] && !w_abort_act;
  assign w_head       = r_mem[r_rd_ptr];
  assign w_pop        = (r_count != '0) && m_if.ready && !w_abort_act;
  // Final pop may coincide with the DRAIN exit so done follows the last transfer directly.
  assign w_drained    = (w_inflight == '0) &&
                        ((r_count == '0) || ((r_count == CNT_W'(1)) && w_pop));

  // Modulo-L wrap by compare/subtract; operands are always below L so one subtract suffices.
  assign w_base_sum = {1'b0, r_base} + (ADDR_W+1)'(HOP);
  assign w_addr_sum = {1'b0, r_addr} + (ADDR_W+1)'(1);
  assign w_base_nxt = (w_base_sum >= (ADDR_W+1)'(L)) ? ADDR_W'(w_base_sum - (ADDR_W+1)'(L))
                                                      : ADDR_W'(w_base_sum);
  assign w_addr_nxt = (w_addr_sum >= (ADDR_W+1)'(L)) ? ADDR_W'(w_addr_sum - (ADDR_W+1)'(L))
                                                      : ADDR_W'(w_addr_sum);

  // Sequencer state, read address generation and output frame index.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_base       <= '0;
      r_addr       <= '0;
      r_samp_left  <= '0;
      r_frame_cnt  <= '0;
      r_num_frames <= '0;
      r_frame_idx  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_act) begin
            r_state      <= S_RUN;
            r_base       <= '0;
            r_addr       <= '0;
            r_samp_left  <= SAMP_W'(N - 1);
            r_frame_cnt  <= '0;
            r_num_frames <= i_num_frames;
          end
        end
        S_RUN: begin
          if (w_abort_act) begin
            r_state <= S_FLUSH;
          end else if (w_issue) begin
            if (w_last_samp) begin
              r_samp_left <= SAMP_W'(N - 1);
              r_frame_cnt <= r_frame_cnt + 16'd1;
              r_base      <= w_base_nxt;
              r_addr      <= w_base_nxt;
              if (w_last_frame) r_state <= S_DRAIN;
            end else begin
              r_samp_left <= r_samp_left - SAMP_W'(1);
              r_addr      <= w_addr_nxt;
            end
          end
        end
        S_DRAIN: begin
          if (w_abort_act)    r_state <= S_FLUSH;
          else if (w_drained) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        S_FLUSH: if (w_inflight == '0) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      if (w_start_act)                         r_frame_idx <= '0;
      else if (w_pop && w_head[DATA_W+1])      r_frame_idx <= r_frame_idx + 16'd1;
    end
  end

  // Latency line carrying first/last tags alongside each outstanding read.
  always_ff @(posedge i_clk) begin
    if (i_rst || w_abort_act) begin
      r_pipe_vld   <= '0;
      r_pipe_first <= '0;
      r_pipe_last  <= '0;
    end else begin
      r_pipe_vld[0]   <= w_issue;
      r_pipe_first[0] <= w_issue && (r_samp_left == SAMP_W'(N - 1));
      r_pipe_last[0]  <= w_issue && w_last_samp;
      for (int k = 1; k < RD_LAT; k++) begin
        r_pipe_vld[k]   <= r_pipe_vld[k-1];
        r_pipe_first[k] <= r_pipe_first[k-1];
        r_pipe_last[k]  <= r_pipe_last[k-1];
      end
    end
  end

  // FIFO pointers and occupancy; abort empties it in one cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst || w_abort_act) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      if (w_pop) r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents need no reset because outputs are gated by occupancy.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_wr) begin
      r_mem[r_wr_ptr] <= {r_pipe_last[RD_LAT-1], r_pipe_first[RD_LAT-1], i_src_data};
    end
  end

  assign o_src_en    = w_issue;
  assign o_src_addr  = r_addr;
  assign m_if.valid  = (r_count != '0);
  assign m_if.data   = m_if.valid ? w_head[DATA_W-1:0] : '0;
  assign m_if.first  = m_if.valid && w_head[DATA_W];
  assign m_if.last   = m_if.valid && w_head[DATA_W+1];
  assign o_frame_idx = r_frame_idx;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);
endmodule

// File: tb/tb_frame_streamer.sv
// Bench for frame_streamer: fixed-latency source returning its own address, randomized
// consumer ready, and a queue of expected samples built from frame/hop/wrap arithmetic.
module tb_frame_streamer;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int L      = 20;
  localparam int N      = 8;
  localparam int HOP    = 4;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = RD_LAT + 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [15:0]       num_frames = '0;
  logic              src_en;
  logic [ADDR_W-1:0] src_addr;
  logic [DATA_W-1:0] src_data;
  logic [15:0]       frame_idx;
  logic              busy;
  logic              done;

  frame_streamer_if #(.DATA_W(DATA_W)) s_if ();

  frame_streamer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .L(L), .N(N), .HOP(HOP), .RD_LAT(RD_LAT)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_num_frames (num_frames),
    .i_abort      (abort),
    .o_src_en     (src_en),
    .o_src_addr   (src_addr),
    .i_src_data   (src_data),
    .m_if         (s_if),
    .o_frame_idx  (frame_idx),
    .o_busy       (busy),
    .o_done       (done)
  );

  always #5 clk = ~clk;

  // Source memory model: source[a] = a, returned RD_LAT cycles after the strobe.
  logic [DATA_W-1:0] sp [RD_LAT];
  always @(posedge clk) begin
    sp[0] <= src_en ? DATA_W'(src_addr) : 32'hBAD0_0000;
    for (int k = 1; k < RD_LAT; k++) sp[k] <= sp[k-1];
  end
  assign src_data = sp[RD_LAT-1];

  typedef struct {
    int unsigned data;
    bit          first;
    bit          last;
    int unsigned fidx;
  } smp_t;
  smp_t exp_q[$];
  smp_t mon_e;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  int cyc = 0, xfers = 0, issued = 0, popped = 0;
  int done_cnt = 0, done_cyc = -1, last_xfer_cyc = -1;
  bit prev_stall = 0;
  logic [DATA_W-1:0] prev_data;
  logic prev_first, prev_last;
  bit rand_ready = 0;

  // Stream monitor: ordering against the model, hold-while-stalled, and read credit.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_stall = 0;
      issued = 0;
      popped = 0;
    end else begin
      if (prev_stall) begin
        check_eq("hold_valid", 64'(s_if.valid), 64'd1);
        check_eq("hold_data", 64'(s_if.data), 64'(prev_data));
        check_eq("hold_first", 64'(s_if.first), 64'(prev_first));
        check_eq("hold_last", 64'(s_if.last), 64'(prev_last));
      end
      if (src_en) begin
        check_eq("credit", 64'((issued - popped) < DEPTH), 64'd1);
        issued++;
      end
      if (s_if.valid && s_if.ready && !abort) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_xfer", 64'd1, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("data", 64'(s_if.data), 64'(mon_e.data));
          check_eq("first", 64'(s_if.first), 64'(mon_e.first));
          check_eq("last", 64'(s_if.last), 64'(mon_e.last));
          check_eq("frame_idx", 64'(frame_idx), 64'(mon_e.fidx));
        end
        xfers++;
        popped++;
        last_xfer_cyc = cyc;
      end
      prev_stall = s_if.valid && !s_if.ready && !abort;
      prev_data  = s_if.data;
      prev_first = s_if.first;
      prev_last  = s_if.last;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (abort && busy) begin
        issued = 0;
        popped = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) s_if.ready = ($urandom_range(0, 1) == 1);
  endtask

  task automatic load_exp(input int nf);
    smp_t e;
    for (int k = 0; k < nf; k++) begin
      for (int i = 0; i < N; i++) begin
        e.data  = (k * HOP + i) % L;
        e.first = (i == 0);
        e.last  = (i == N - 1);
        e.fidx  = k % 65536;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic pulse_start(input int nf);
    num_frames = 16'(nf);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_src_en"}, 64'(src_en), 64'd0);
    check_eq({tag, "_src_addr"}, 64'(src_addr), 64'd0);
    check_eq({tag, "_m_valid"}, 64'(s_if.valid), 64'd0);
    check_eq({tag, "_m_data"}, 64'(s_if.data), 64'd0);
    check_eq({tag, "_m_first"}, 64'(s_if.first), 64'd0);
    check_eq({tag, "_m_last"}, 64'(s_if.last), 64'd0);
    check_eq({tag, "_frame_idx"}, 64'(frame_idx), 64'd0);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_done"}, 64'(done), 64'd0);
  endtask

  // Full run of nf frames; optionally re-pulses start mid-run, which must be ignored.
  task automatic run_frames(input string tag, input int nf, input bit rnd, input bit inject);
    int t;
    exp_q.delete();
    load_exp(nf);
    done_cnt = 0;
    xfers = 0;
    rand_ready = rnd;
    s_if.ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
    pulse_start(nf);
    t = 0;
    while (done_cnt == 0 && t < 2000) begin
      if (inject && t == 5) begin
        num_frames = 16'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
      end else begin
        tick();
      end
      t++;
    end
    check_eq({tag, "_done_seen"}, 64'(done_cnt > 0), 64'd1);
    tick();
    tick();
    rand_ready = 0;
    s_if.ready = 1'b1;
    check_eq({tag, "_xfers"}, 64'(xfers), 64'(nf * N));
    check_eq({tag, "_exp_left"}, 64'(exp_q.size()), 64'd0);
    check_eq({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    check_eq({tag, "_done_timing"}, 64'(done_cyc), 64'(last_xfer_cyc + 1));
    check_eq({tag, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    s_if.ready = 1'b1;
    rst = 1'b1;
    repeat (3) tick();
    check_idle_outputs("reset");
    rst = 1'b0;
    tick();

    run_frames("t1", 2, 1'b0, 1'b0);
    run_frames("t2", 5, 1'b0, 1'b0);
    run_frames("t3", 3, 1'b1, 1'b0);
    run_frames("t3b", 4, 1'b1, 1'b0);

    // Continuous run aborted after 10 transfers.
    exp_q.delete();
    load_exp(4);
    done_cnt = 0;
    xfers = 0;
    s_if.ready = 1'b1;
    pulse_start(0);
    t = 0;
    while (xfers < 10 && t < 500) begin
      tick();
      t++;
    end
    check_eq("t4_reach10", 64'(xfers), 64'd10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_q.delete();
    check_eq("t4_valid_off", 64'(s_if.valid), 64'd0);
    check_eq("t4_src_en_off", 64'(src_en), 64'd0);
    t = 1;
    while (busy && t < 20) begin
      tick();
      t++;
    end
    check_eq("t4_busy_low_in_time", 64'(t <= RD_LAT + 1), 64'd1);
    check_eq("t4_no_done", 64'(done_cnt), 64'd0);
    check_eq("t4_fidx_held", 64'(frame_idx), 64'(10 / N));
    repeat (4) tick();
    check_eq("t4_valid_idle", 64'(s_if.valid), 64'd0);
    run_frames("t4_restart", 1, 1'b0, 1'b0);

    // start during RUN ignored; start+abort together in IDLE does nothing.
    run_frames("t5_inject", 2, 1'b0, 1'b1);
    num_frames = 16'd1;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    tick();
    check_eq("t5_abort_wins_busy", 64'(busy), 64'd0);
    check_eq("t5_abort_wins_src", 64'(src_en), 64'd0);
    run_frames("t5_after", 2, 1'b0, 1'b0);

    // Reset mid-frame with reads outstanding.
    exp_q.delete();
    load_exp(2);
    xfers = 0;
    s_if.ready = 1'b1;
    pulse_start(2);
    t = 0;
    while (xfers < 3 && t < 200) begin
      tick();
      t++;
    end
    check_eq("t6_reach3", 64'(xfers), 64'd3);
    rst = 1'b1;
    tick();
    check_idle_outputs("t6_rst");
    rst = 1'b0;
    exp_q.delete();
    tick();
    run_frames("t6_rerun", 2, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
